jt51_logsin: RTL and testbench

//  Phase-to-log-sine front end of the operator path. Mirrors the per-slot
//  10-bit phase into a quarter wave, drives the phase ROM address/select,

---
 rtl/jt51_logsin.sv | 130 +++++++++++++
 tb/tb_jt51_logsin.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/jt51_logsin.sv
// jt51_logsin: phase -> log-sine front end.
// Folds the phase into a quarter wave and addresses the phase ROM. It captures
// the ROM word and interpolates odd phases with the delta field. The result is
// a 12-bit attenuation, the sign and a slot tag. Three register stages in all.
module jt51_logsin #(
    parameter int PH_W  = 10,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [PH_W-1:0]  phase_in,
    input  logic             zero,
    output logic [4:0]       rom_addr,
    output logic [1:0]       rom_sel,
    input  logic [18:0]      rom_ph,
    output logic [OUT_W-1:0] logsin,
    output logic             sign_out,
    output logic [4:0]       slot_out,
    output logic             valid_out
);

    // S1: ROM address/select plus side-band bits that travel with the sample
    logic [4:0]       rom_addr_q, rom_addr_d;
    logic [1:0]       rom_sel_q,  rom_sel_d;
    logic             lsb1_q, lsb1_d, sgn1_q, sgn1_d, z1_q, z1_d;
    // S2: captured ROM word
    logic [18:0]      rom_ph_q, rom_ph_d;
    logic             lsb2_q, lsb2_d, sgn2_q, sgn2_d, z2_q, z2_d;
    // S3: outputs
    logic [OUT_W-1:0] logsin_q, logsin_d;
    logic             sign_q, sign_d;
    logic [4:0]       slot_q, slot_d;
    // valid shift register: [0]=S1, [1]=S2, [2]=valid_out
    logic [2:0]       vld_pipe_q, vld_pipe_d;

    logic [7:0]       pm;
    logic [OUT_W:0]   sum;

    // Next-state for every stage; everything holds while cen is low
    always_comb begin
        pm  = phase_in[8] ? ~phase_in[7:0] : phase_in[7:0];
        // 13-bit sum so a carry out can be detected and clamped
        sum = {1'b0, rom_ph_q[18:7]} + {6'd0, rom_ph_q[6:0]};

        rom_addr_d = rom_addr_q;
        rom_sel_d  = rom_sel_q;
        lsb1_d     = lsb1_q;
        sgn1_d     = sgn1_q;
        z1_d       = z1_q;
        rom_ph_d   = rom_ph_q;
        lsb2_d     = lsb2_q;
        sgn2_d     = sgn2_q;
        z2_d       = z2_q;
        logsin_d   = logsin_q;
        sign_d     = sign_q;
        slot_d     = slot_q;
        vld_pipe_d = vld_pipe_q;

        if (cen) begin
            rom_addr_d = pm[7:3];
            rom_sel_d  = pm[2:1];
            lsb1_d     = pm[0];
            sgn1_d     = phase_in[9];
            z1_d       = zero;

            rom_ph_d   = rom_ph;
            lsb2_d     = lsb1_q;
            sgn2_d     = sgn1_q;
            z2_d       = z1_q;

            // odd quarter-phase: interpolate halfway using the delta field
            if (lsb2_q)
                logsin_d = sum[OUT_W] ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
            else
                logsin_d = rom_ph_q[18:7];
            sign_d = sgn2_q;

            // slot sync marker beats the free-running increment
            if (z2_q)
                slot_d = 5'd0;
            else if (vld_pipe_q[2])
                slot_d = slot_q + 5'd1;

            // stage valids only mark that a cen edge has filled the stage
            vld_pipe_d = {vld_pipe_q[1:0], 1'b1};
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q <= '0;
            rom_sel_q  <= '0;
            lsb1_q     <= 1'b0;
            sgn1_q     <= 1'b0;
            z1_q       <= 1'b0;
            rom_ph_q   <= '0;
            lsb2_q     <= 1'b0;
            sgn2_q     <= 1'b0;
            z2_q       <= 1'b0;
            logsin_q   <= '0;
            sign_q     <= 1'b0;
            slot_q     <= '0;
            vld_pipe_q <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            rom_sel_q  <= rom_sel_d;
            lsb1_q     <= lsb1_d;
            sgn1_q     <= sgn1_d;
            z1_q       <= z1_d;
            rom_ph_q   <= rom_ph_d;
            lsb2_q     <= lsb2_d;
            sgn2_q     <= sgn2_d;
            z2_q       <= z2_d;
            logsin_q   <= logsin_d;
            sign_q     <= sign_d;
            slot_q     <= slot_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rom_sel   = rom_sel_q;
    assign logsin    = logsin_q;
    assign sign_out  = sign_q;
    assign slot_out  = slot_q;
    assign valid_out = vld_pipe_q[2];

endmodule

// File: tb/tb_jt51_logsin.sv
// tb_jt51_logsin: directed + random phases against a queue-based reference.
module tb_jt51_logsin;

    logic        clk = 1'b0;
    logic        rst, cen, zero;
    logic [9:0]  phase_in;
    logic [4:0]  rom_addr;
    logic [1:0]  rom_sel;
    logic [18:0] rom_ph;
    logic [11:0] logsin;
    logic        sign_out, valid_out;
    logic [4:0]  slot_out;

    logic [18:0] rom_tab [0:127];

    always #5 clk = ~clk;

    assign rom_ph = rom_tab[{rom_addr, rom_sel}];

    jt51_logsin dut (
        .clk(clk), .rst(rst), .cen(cen), .phase_in(phase_in), .zero(zero),
        .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_ph(rom_ph),
        .logsin(logsin), .sign_out(sign_out), .slot_out(slot_out),
        .valid_out(valid_out)
    );

    typedef struct packed {
        logic [11:0] ls;
        logic        sg;
        logic        z;
    } samp_t;

    samp_t       pend[$];
    samp_t       cur;
    logic        exp_v;
    logic [4:0]  exp_slot;
    logic [4:0]  exp_addr;
    logic [1:0]  exp_sel;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: fold the phase into 0..255, look the pair up, interpolate odd points
    function automatic samp_t model(input logic [9:0] p, input logic z);
        samp_t s;
        int q, base, delta, v;
        q     = p[8] ? 255 - int'(p[7:0]) : int'(p[7:0]);
        base  = int'(rom_tab[q / 2]) / 128;
        delta = int'(rom_tab[q / 2]) % 128;
        v     = (q % 2 == 1) ? base + delta : base;
        if (v > 4095) v = 4095;
        s.ls = v[11:0];
        s.sg = p[9];
        s.z  = z;
        return s;
    endfunction

    task automatic check_all();
        chk("valid_out", valid_out, exp_v);
        chk("slot_out", slot_out, exp_slot);
        chk("rom_addr", rom_addr, exp_addr);
        chk("rom_sel", rom_sel, exp_sel);
        if (exp_v) begin
            chk("logsin", logsin, cur.ls);
            chk("sign_out", sign_out, cur.sg);
        end
    endtask

    task automatic step(input logic [9:0] p, input logic z, input logic c);
        int q;
        rst = 1'b0; phase_in = p; zero = z; cen = c;
        @(posedge clk); #1;
        if (c) begin
            q = p[8] ? 255 - int'(p[7:0]) : int'(p[7:0]);
            exp_addr = 5'(q / 8);
            exp_sel  = 2'((q / 2) % 4);
            pend.push_back(model(p, z));
            if (pend.size() >= 3) begin
                cur = pend.pop_front();
                if (cur.z) exp_slot = 5'd0;
                else if (exp_v) exp_slot = exp_slot + 5'd1;
                exp_v = 1'b1;
            end
        end
        check_all();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst = 1'b1; cen = i[0]; zero = 1'($urandom); phase_in = 10'($urandom);
            @(posedge clk); #1;
            chk("rst_logsin", logsin, 0);
            chk("rst_sign", sign_out, 0);
            chk("rst_slot", slot_out, 0);
            chk("rst_valid", valid_out, 0);
            chk("rst_addr", rom_addr, 0);
            chk("rst_sel", rom_sel, 0);
        end
        pend.delete();
        exp_v = 1'b0; exp_slot = 5'd0; exp_addr = 5'd0; exp_sel = 2'd0;
        cur = '0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom_tab[i] = 19'($urandom);
        rom_tab[2]   = 19'h00083;                // addr0/sel2: base 1, delta 3
        rom_tab[125] = {12'h5A5, 7'h11};         // addr31/sel1
        rom_tab[7]   = {12'hFFE, 7'h05};         // addr1/sel3: saturates on odd
        rst = 1'b1; cen = 1'b0; zero = 1'b0; phase_in = '0;

        // reset with cen toggling, then the valid ramp (with a cen gap)
        do_reset(4);
        step(10'h004, 1'b0, 1'b1);
        step(10'h000, 1'b0, 1'b0);
        step(10'h105, 1'b0, 1'b1);
        chk("addr_105", rom_addr, 31);
        chk("sel_105", rom_sel, 1);
        step(10'h305, 1'b0, 1'b1);
        chk("t2_logsin", logsin, 12'h001);
        chk("t2_sign", sign_out, 0);
        step(10'h00F, 1'b0, 1'b1);
        chk("t3_logsin", logsin, 12'h5A5);
        step(10'h0FF, 1'b0, 1'b1);
        chk("t3_sign_neg", sign_out, 1);
        chk("addr_0ff", rom_addr, 31);
        chk("sel_0ff", rom_sel, 3);
        step(10'h100, 1'b0, 1'b1);
        chk("t4_sat", logsin, 12'hFFF);
        chk("addr_100", rom_addr, 31);
        chk("sel_100", rom_sel, 3);
        step(10'h200, 1'b0, 1'b1);
        chk("addr_200", rom_addr, 0);
        step(10'h000, 1'b0, 1'b1);
        step(10'h000, 1'b0, 1'b1);
        chk("sign_200", sign_out, 1);

        // slot stream: zero on slot 7, full-frame wrap, then a mid-frame re-sync
        for (int i = 0; i < 80; i++)
            step(10'($urandom), (i == 7) || (i == 39) || (i == 55), 1'b1);

        // cen held low mid-stream, then resume
        for (int i = 0; i < 5; i++) step(10'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(10'($urandom), 1'($urandom_range(0, 15) == 0), 1'($urandom));

        // mid-stream reset flushes everything
        do_reset(2);
        for (int i = 0; i < 40; i++) step(10'($urandom), 1'($urandom_range(0, 20) == 0), 1'($urandom_range(0, 3) != 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
